general_register_file: RTL and testbench
========================================

// Module: general_register_file
//
// PURPOSE
// - Operand store directly upstream of the ALU: 4 general registers (R1-R4) + 4 scratch registers (S1-S4).
// - Two independently selected read ports OutA/OutB drive ALU inputs A/B.
// - The ALU result (or any bus value) returns on I and is written under a per-cycle micro-operation (FunSel).
// - Register-level ops (inc/dec/load/clear/byte-load) execute here, so the ALU is free for two-operand work.
//
// PARAMETERS
// - DATA_W     32   register/port width; must be >= 16 (byte and half-word ops below)
// - RESET_VAL  0    value every register takes on Reset
//
// PORTS
// - Clock    in   1       single clock; all state updates on rising edge
// - Reset    in   1       synchronous, active-high; clears all 8 registers to RESET_VAL
// - I        in   DATA_W  write data (ALU result / memory / bus)
// - FunSel   in   3       micro-operation applied to every enabled register
// - RegSel   in   4       GPR write enables, active-high; bit3=R1, bit2=R2, bit1=R3, bit0=R4
// - ScrSel   in   4       scratch write enables, active-high; bit3=S1 ... bit0=S4
// - OutASel  in   3       read select A: 000..011 = R1..R4, 100..111 = S1..S4
// - OutBSel  in   3       read select B: same encoding as OutASel
// - OutA     out  DATA_W  selected register value -> ALU A
// - OutB     out  DATA_W  selected register value -> ALU B
//
// BEHAVIOUR
// Reset
// - Reset=1 at a rising edge: all registers := RESET_VAL, regardless of RegSel/ScrSel/FunSel.
// - Reset asserted while an op is pending: the op is discarded.
// - OutA/OutB show RESET_VAL from the cycle after the reset edge.
//
// Writes
// - Register Q updates only if its RegSel/ScrSel bit is 1.
// - Unselected registers hold their value.
// - All selected registers (any mix, both groups at once) apply the same FunSel on the same edge, each from its own old Q.
//
// FunSel (new Q on the rising edge)
// - 000  Q-1, modulo 2^DATA_W (0 -> all-ones)
// - 001  Q+1, modulo 2^DATA_W (all-ones -> 0)
// - 010  I
// - 011  0
// - 100  {zeros, I[7:0]}           clear, load low byte
// - 101  {Q[DATA_W-1:8], I[7:0]}   low byte only, upper bits kept
// - 110  {Q[DATA_W-9:0], I[7:0]}   shift left one byte, insert I[7:0]
// - 111  sign-extend I[15:0] to DATA_W
//
// Reads
// - OutA/OutB are a combinational mux of current register state; zero-latency read.
// - A write on edge N is visible on OutA/OutB after edge N; no write-through within the cycle.
// - OutASel == OutBSel is legal; both ports show the same value.
// - No flags or carry are produced here; inc/dec wrap silently.
//
// STRUCTURE
// - Shared package (alu_sys_pkg):
//   - FunSel encodings as localparams (RF_DEC, RF_INC, RF_LOAD, RF_CLR, RF_LDLO_CLR, RF_LDLO, RF_SHLB, RF_SEXT16)
//   - read-select encodings (SEL_R1..SEL_S4)
// - Sub-module gp_register: one DATA_W register with Clock, Reset, E (enable), FunSel, I -> Q.
//   - Instantiated 8x: RegSel/ScrSel bits drive E.
// - Top level contains the two 8:1 read muxes only.
//
// TESTING
// 1. Reset=1 one cycle with RegSel=ScrSel=4'hF, FunSel=010, I=32'hDEADBEEF -> all 8 registers read 0 (sweep OutASel 0..7).
// 2. FunSel=010, I=32'h12345678, RegSel=4'b1000 -> OutASel=000 gives 32'h12345678 next cycle; R2..R4 and S1..S4 unchanged.
// 3. R2=0, FunSel=000, RegSel=0100 -> 32'hFFFFFFFF; then FunSel=001 -> 32'h00000000.
// 4. R1=32'hAABBCCDD, I=32'h00000011:
//    - FunSel=101 -> 32'hAABBCC11
//    - FunSel=110 -> 32'hBBCC1111
//    - FunSel=100 -> 32'h00000011
// 5. I=32'h00008001, FunSel=111, ScrSel=0001 -> S4 = 32'hFFFF8001; with I=32'h00007FFF -> S4 = 32'h00007FFF.
// 6. RegSel=1111 and ScrSel=1111 with FunSel=001, registers preloaded with distinct values -> each register +1 independently.
//    - Same cycle, OutA (sel 000) and OutB (sel 111) still show old values.
//    - Reset in the following cycle overrides a concurrent load.

Source files
------------

// File: rtl/alu_sys_pkg.sv
// Shared encodings for the ALU subsystem: register-file micro-operations
// and read-port select codes.
package alu_sys_pkg;

  // FunSel micro-operations applied to every enabled register
  localparam logic [2:0] RF_DEC      = 3'b000;
  localparam logic [2:0] RF_INC      = 3'b001;
  localparam logic [2:0] RF_LOAD     = 3'b010;
  localparam logic [2:0] RF_CLR      = 3'b011;
  localparam logic [2:0] RF_LDLO_CLR = 3'b100;
  localparam logic [2:0] RF_LDLO     = 3'b101;
  localparam logic [2:0] RF_SHLB     = 3'b110;
  localparam logic [2:0] RF_SEXT16   = 3'b111;

  // Read-port select codes; the code doubles as the register array index
  localparam logic [2:0] SEL_R1 = 3'b000;
  localparam logic [2:0] SEL_R2 = 3'b001;
  localparam logic [2:0] SEL_R3 = 3'b010;
  localparam logic [2:0] SEL_R4 = 3'b011;
  localparam logic [2:0] SEL_S1 = 3'b100;
  localparam logic [2:0] SEL_S2 = 3'b101;
  localparam logic [2:0] SEL_S3 = 3'b110;
  localparam logic [2:0] SEL_S4 = 3'b111;

endpackage

// File: rtl/gp_register.sv
// Single DATA_W-wide register executing one FunSel micro-operation per
// enabled clock edge. Inc/dec wrap silently; no flags are produced.
module gp_register
  import alu_sys_pkg::*;
#(
  parameter int unsigned           DATA_W    = 32,
  parameter logic [DATA_W-1:0]     RESET_VAL = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              E,
  input  logic [2:0]        FunSel,
  input  logic [DATA_W-1:0] I,
  output logic [DATA_W-1:0] Q
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  // Next value for the selected micro-operation, computed from the old Q
  always_comb begin
    q_d = q_q;
    case (FunSel)
      RF_DEC:      q_d = q_q - DATA_W'(1);
      RF_INC:      q_d = q_q + DATA_W'(1);
      RF_LOAD:     q_d = I;
      RF_CLR:      q_d = '0;
      RF_LDLO_CLR: begin
        q_d      = '0;
        q_d[7:0] = I[7:0];
      end
      RF_LDLO:     q_d[7:0] = I[7:0];
      RF_SHLB:     q_d = {q_q[DATA_W-9:0], I[7:0]};
      RF_SEXT16: begin
        // Fill with the half-word sign, then overlay the half-word itself
        q_d       = {DATA_W{I[15]}};
        q_d[15:0] = I[15:0];
      end
      default:     q_d = q_q;
    endcase
  end

  // Synchronous reset dominates; otherwise update only when enabled
  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q <= RESET_VAL;
    end else if (E) begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/general_register_file.sv
// Operand store ahead of the ALU: R1-R4 and S1-S4, each a gp_register,
// with two independent zero-latency 8:1 read ports.
module general_register_file
  import alu_sys_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] I,
  input  logic [2:0]        FunSel,
  input  logic [3:0]        RegSel,
  input  logic [3:0]        ScrSel,
  input  logic [2:0]        OutASel,
  input  logic [2:0]        OutBSel,
  output logic [DATA_W-1:0] OutA,
  output logic [DATA_W-1:0] OutB
);

  logic [DATA_W-1:0] regs [8];
  logic [7:0]        en;

  // Array index equals the read-select code: 0..3 = R1..R4, 4..7 = S1..S4.
  // Select bit 3 addresses the first register of each group.
  assign en = {ScrSel[0], ScrSel[1], ScrSel[2], ScrSel[3],
               RegSel[0], RegSel[1], RegSel[2], RegSel[3]};

  for (genvar g = 0; g < 8; g++) begin : g_reg
    gp_register #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VAL)
    ) u_reg (
      .Clock  (Clock),
      .Reset  (Reset),
      .E      (en[g]),
      .FunSel (FunSel),
      .I      (I),
      .Q      (regs[g])
    );
  end

  // Read port A: combinational mux of current register state
  always_comb begin
    OutA = '0;
    case (OutASel)
      SEL_R1:  OutA = regs[0];
      SEL_R2:  OutA = regs[1];
      SEL_R3:  OutA = regs[2];
      SEL_R4:  OutA = regs[3];
      SEL_S1:  OutA = regs[4];
      SEL_S2:  OutA = regs[5];
      SEL_S3:  OutA = regs[6];
      SEL_S4:  OutA = regs[7];
      default: OutA = '0;
    endcase
  end

  // Read port B: same encoding as port A
  always_comb begin
    OutB = '0;
    case (OutBSel)
      SEL_R1:  OutB = regs[0];
      SEL_R2:  OutB = regs[1];
      SEL_R3:  OutB = regs[2];
      SEL_R4:  OutB = regs[3];
      SEL_S1:  OutB = regs[4];
      SEL_S2:  OutB = regs[5];
      SEL_S3:  OutB = regs[6];
      SEL_S4:  OutB = regs[7];
      default: OutB = '0;
    endcase
  end

endmodule

// File: tb/tb_general_register_file.sv
// Self-checking bench for general_register_file: a table of single-edge
// vectors plus hand-written sequences for the multi-register and reset cases.
module tb_general_register_file;

  logic        Clock;
  logic        Reset;
  logic [31:0] I;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic [31:0] OutA;
  logic [31:0] OutB;

  general_register_file #(
    .DATA_W    (32),
    .RESET_VAL (32'h0)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .I       (I),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .ScrSel  (ScrSel),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .OutA    (OutA),
    .OutB    (OutB)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic        rst;
    logic [2:0]  fs;
    logic [3:0]  rs;
    logic [3:0]  ss;
    logic [31:0] i;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_tests;
  int   n_fail;

  function automatic vec_t mk(string name, logic rst, logic [2:0] fs,
                              logic [3:0] rs, logic [3:0] ss, logic [31:0] i,
                              logic [2:0] sa, logic [2:0] sb,
                              logic [31:0] ea, logic [31:0] eb);
    vec_t v;
    v.name = name; v.rst = rst; v.fs = fs; v.rs = rs; v.ss = ss; v.i = i;
    v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic push_exp(string name, logic [31:0] a, logic [31:0] b);
    exp_t e;
    e.name = name; e.a = a; e.b = b;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare both read ports against it
  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    n_tests++;
    if (OutA !== e.a) begin
      n_fail++;
      $display("FAIL %s.A: got %08h expected %08h", e.name, OutA, e.a);
    end
    n_tests++;
    if (OutB !== e.b) begin
      n_fail++;
      $display("FAIL %s.B: got %08h expected %08h", e.name, OutB, e.b);
    end
  endtask

  task automatic drive(logic rst, logic [2:0] fs, logic [3:0] rs,
                       logic [3:0] ss, logic [31:0] i,
                       logic [2:0] sa, logic [2:0] sb);
    Reset = rst; FunSel = fs; RegSel = rs; ScrSel = ss; I = i;
    OutASel = sa; OutBSel = sb;
  endtask

  logic [31:0] pre [8];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive(1'b0, 3'b000, 4'h0, 4'h0, 32'h0, 3'd0, 3'd0);

    // rst fs rs ss i sa sb -> expected OutA OutB after the edge
    vecs.push_back(mk("reset_load_ignored", 1, 3'b010, 4'hF, 4'hF, 32'hDEADBEEF, 0, 7, 32'h0, 32'h0));
    vecs.push_back(mk("reset_sweep_r1_s4",  0, 3'b010, 4'h0, 4'h0, 32'hFFFFFFFF, 0, 7, 32'h0, 32'h0));
    vecs.push_back(mk("reset_sweep_r2_s3",  0, 3'b010, 4'h0, 4'h0, 32'hFFFFFFFF, 1, 6, 32'h0, 32'h0));
    vecs.push_back(mk("reset_sweep_r3_s2",  0, 3'b010, 4'h0, 4'h0, 32'hFFFFFFFF, 2, 5, 32'h0, 32'h0));
    vecs.push_back(mk("reset_sweep_r4_s1",  0, 3'b010, 4'h0, 4'h0, 32'hFFFFFFFF, 3, 4, 32'h0, 32'h0));
    vecs.push_back(mk("load_r1",            0, 3'b010, 4'h8, 4'h0, 32'h12345678, 0, 1, 32'h12345678, 32'h0));
    vecs.push_back(mk("unsel_r3_s1",        0, 3'b010, 4'h0, 4'h0, 32'hFFFFFFFF, 2, 4, 32'h0, 32'h0));
    vecs.push_back(mk("unsel_r4_s2",        0, 3'b010, 4'h0, 4'h0, 32'hFFFFFFFF, 3, 5, 32'h0, 32'h0));
    vecs.push_back(mk("unsel_s3_s4",        0, 3'b010, 4'h0, 4'h0, 32'hFFFFFFFF, 6, 7, 32'h0, 32'h0));
    vecs.push_back(mk("dec_r2_wrap",        0, 3'b000, 4'h4, 4'h0, 32'h0,        1, 0, 32'hFFFFFFFF, 32'h12345678));
    vecs.push_back(mk("inc_r2_wrap",        0, 3'b001, 4'h4, 4'h0, 32'h0,        1, 0, 32'h0, 32'h12345678));
    vecs.push_back(mk("load_r1_aabb",       0, 3'b010, 4'h8, 4'h0, 32'hAABBCCDD, 0, 0, 32'hAABBCCDD, 32'hAABBCCDD));
    vecs.push_back(mk("ldlo_keep_upper",    0, 3'b101, 4'h8, 4'h0, 32'h00000011, 0, 1, 32'hAABBCC11, 32'h0));
    vecs.push_back(mk("shift_byte",         0, 3'b110, 4'h8, 4'h0, 32'h00000011, 0, 1, 32'hBBCC1111, 32'h0));
    vecs.push_back(mk("ldlo_clear",         0, 3'b100, 4'h8, 4'h0, 32'hFFFFFF11, 0, 1, 32'h00000011, 32'h0));
    vecs.push_back(mk("clear_r1",           0, 3'b011, 4'h8, 4'h0, 32'hFFFFFFFF, 0, 1, 32'h0, 32'h0));
    vecs.push_back(mk("sext_neg_s4",        0, 3'b111, 4'h0, 4'h1, 32'h00008001, 7, 0, 32'hFFFF8001, 32'h0));
    vecs.push_back(mk("sext_pos_s4",        0, 3'b111, 4'h0, 4'h1, 32'hFFFF7FFF, 7, 0, 32'h00007FFF, 32'h0));
    vecs.push_back(mk("load_s1",            0, 3'b010, 4'h0, 4'h8, 32'h5A5A5A5A, 4, 7, 32'h5A5A5A5A, 32'h00007FFF));
    vecs.push_back(mk("load_r4",            0, 3'b010, 4'h1, 4'h0, 32'hC3C3C3C3, 3, 4, 32'hC3C3C3C3, 32'h5A5A5A5A));

    foreach (vecs[k]) begin
      @(negedge Clock);
      drive(vecs[k].rst, vecs[k].fs, vecs[k].rs, vecs[k].ss, vecs[k].i,
            vecs[k].sa, vecs[k].sb);
      push_exp(vecs[k].name, vecs[k].ea, vecs[k].eb);
      @(posedge Clock);
      #1;
      pop_check();
    end

    // Preload all eight registers with distinct values, S4 at all-ones
    for (int k = 0; k < 8; k++) begin
      pre[k] = (k == 7) ? 32'hFFFFFFFF : 32'h01010101 * (k + 1);
      @(negedge Clock);
      drive(1'b0, 3'b010, (k < 4) ? 4'(8 >> k) : 4'h0,
            (k >= 4) ? 4'(8 >> (k - 4)) : 4'h0, pre[k], 3'(k), 3'(k));
      push_exp("preload", pre[k], pre[k]);
      @(posedge Clock);
      #1;
      pop_check();
    end

    // Increment everything at once; before the edge the ports show old values
    @(negedge Clock);
    drive(1'b0, 3'b001, 4'hF, 4'hF, 32'h0, 3'd0, 3'd7);
    #1;
    push_exp("inc_all_before_edge", pre[0], pre[7]);
    pop_check();
    @(posedge Clock);
    #1;
    drive(1'b0, 3'b001, 4'h0, 4'h0, 32'h0, 3'd0, 3'd0);
    for (int k = 0; k < 8; k++) begin
      OutASel = 3'(k);
      OutBSel = 3'(k);
      #1;
      push_exp("inc_all", pre[k] + 32'd1, pre[k] + 32'd1);
      pop_check();
    end

    // Reset coinciding with a load to every register wins
    @(negedge Clock);
    drive(1'b1, 3'b010, 4'hF, 4'hF, 32'hCAFEF00D, 3'd0, 3'd7);
    @(posedge Clock);
    #1;
    push_exp("reset_over_load", 32'h0, 32'h0);
    pop_check();
    @(negedge Clock);
    drive(1'b0, 3'b010, 4'h0, 4'h0, 32'hCAFEF00D, 3'd0, 3'd0);
    for (int k = 0; k < 8; k++) begin
      OutASel = 3'(k);
      OutBSel = 3'(7 - k);
      #1;
      push_exp("reset_over_load_sweep", 32'h0, 32'h0);
      pop_check();
    end

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
